// File: rtl/instr_encoder.sv
// Streaming RV32I/F instruction encoder: packs decoded fields into a 32-bit word and
// queues it in a small FIFO tagged with a byte address. Define INSTR_ENC_FP_EN to accept flw/fsw.
module instr_encoder #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_IALU, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
  } fmt_t;

  fmt_t             fmt;
  logic [31:0]      word;
  logic             bad;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      mem [DEPTH];

  always_comb begin
    fmt = FMT_ILL;
    case (opcode)
      7'b0110011:             fmt = FMT_R;
      7'b0010011:             fmt = FMT_IALU;
      7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b1100011:             fmt = FMT_B;
      7'b0100011:             fmt = FMT_S;
      7'b1101111:             fmt = FMT_J;
`ifdef INSTR_ENC_FP_EN
      7'b0000111:             fmt = FMT_I;
      7'b0100111:             fmt = FMT_S;
`endif
      default:                fmt = FMT_ILL;
    endcase
  end

  // NOTE: every path through a combinational block assigns its outputs (default first), so no latches are inferred.
  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:           word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I, FMT_IALU: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:           word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:           word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:           word = {imm[31:12], rd, opcode};
      FMT_J:           word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:         word = '0;
    endcase
    // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
    if (fmt == FMT_IALU && (funct3 == 3'b001 || funct3 == 3'b101))
      word[31:20] = {funct7, imm[4:0]};
  end

  // Branch/jump offsets must be half-word aligned; anything else is dropped and flagged.
  assign bad    = (fmt == FMT_ILL) || ((fmt == FMT_B || fmt == FMT_J) && imm[0]);
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);

  assign in_ready  = rst_n && !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !bad;
  assign pop       = out_valid && out_ready;

  assign instruction = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array is not reset; an empty FIFO masks the head so stale data never shows.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         addr <= '0;
    else if (addr_load) addr <= start_addr;
    else if (pop)       addr <= addr + ADDR_W'(4);
  end

  // A rejected accept wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n)              err <= 1'b0;
    else if (accept && bad)  err <= 1'b1;
    else if (addr_load)      err <= 1'b0;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a scoreboard queue is filled at each accepted
// bundle and drained as the DUT pops words; address and error flag are tracked alongside.
module tb_instr_encoder;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;
  localparam int BUDGET = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              addr_load;
  logic [ADDR_W-1:0] start_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] addr;
  logic              err;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .addr_load(addr_load), .start_addr(start_addr),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .addr(addr), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] model_addr = '0;
  logic              model_err  = 1'b0;
  bit                mon_en     = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference encoder, written field-by-field from the ISA layouts.
  function automatic void enc_ref(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] im, output logic [31:0] w, output bit is_bad);
    w = '0;
    is_bad = 1'b0;
    w[6:0] = o;
    case (o)
      7'h33: begin
        w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2; w[31:25] = f7;
      end
      7'h13, 7'h03, 7'h67: begin
        w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[31:20] = im[11:0];
        if (o == 7'h13 && (f3 == 3'b001 || f3 == 3'b101)) begin
          w[24:20] = im[4:0]; w[31:25] = f7;
        end
      end
      7'h23: begin
        w[11:7] = im[4:0]; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2; w[31:25] = im[11:5];
      end
      7'h63: begin
        w[7] = im[11]; w[11:8] = im[4:1]; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2;
        w[30:25] = im[10:5]; w[31] = im[12]; is_bad = im[0];
      end
      7'h37, 7'h17: begin
        w[11:7] = d; w[31:12] = im[31:12];
      end
      7'h6F: begin
        w[11:7] = d; w[19:12] = im[19:12]; w[20] = im[11]; w[30:21] = im[10:1];
        w[31] = im[20]; is_bad = im[0];
      end
`ifdef INSTR_ENC_FP_EN
      7'h07: begin
        w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[31:20] = im[11:0];
      end
      7'h27: begin
        w[11:7] = im[4:0]; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2; w[31:25] = im[11:5];
      end
`endif
      default: is_bad = 1'b1;
    endcase
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        check("rst_in_ready", in_ready, 0);
      end else begin
        check("in_ready", in_ready, 64'(exp_q.size() < DEPTH));
        check("out_valid", out_valid, 64'(exp_q.size() != 0));
        check("err", err, model_err);
        if (out_valid && out_ready && exp_q.size() != 0) begin
          check("pop_instr", instruction, exp_q.pop_front());
          check("pop_addr", addr, model_addr);
          model_addr = model_addr + 32'd4;
        end
      end
    end
  end

  // Drives one bundle, waits (bounded) for acceptance and records the expected result.
  task automatic send(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im, input logic [31:0] exp_word, input bit exp_bad,
                      output int waits);
    bit got;
    opcode = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    waits = 0;
    got = 1'b0;
    while (!got && waits < BUDGET) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waits++;
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (exp_bad) model_err = 1'b1;
    else exp_q.push_back(exp_word);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_ref(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] im);
    logic [31:0] w;
    bit b;
    int waits;
    enc_ref(o, d, s1, s2, f3, f7, im, w, b);
    send(o, d, s1, s2, f3, f7, im, w, b, waits);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a);
    addr_load = 1'b1;
    start_addr = a;
    @(posedge clk);
    model_addr = a;
    model_err = 1'b0;
    #1 addr_load = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < BUDGET) begin
      @(posedge clk);
      cyc++;
    end
    check("drain_timeout", 64'(exp_q.size()), 0);
    #1;
  endtask

  initial begin
    int w0, w1, w2, w3, wc;
    logic [31:0] hold_i;
    logic [ADDR_W-1:0] hold_a;
    logic [6:0] ops [12];

    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0; addr_load = 1'b0; start_addr = '0; out_ready = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_instruction", instruction, 0);
    check("reset_addr", addr, 0);
    check("reset_err", err, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // add x3,x1,x2: visible one cycle after accept, at address 0
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0, w0);
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_word", instruction, 32'h002081B3);
    check("add_addr", addr, 0);
    @(posedge clk); #1;
    drain();

    // back-to-back stream with the consumer always ready
    out_ready = 1'b1;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, w0);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0, w1);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0, w2);
    send(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3, 32'h40335293, 1'b0, w3);
    check("b2b_stalls", 64'(w0 + w1 + w2 + w3), 0);
    drain();

    // address load then three pops; then wrap at the top of the address space
    load(32'h100);
    @(negedge clk);
    check("load_addr", addr, 32'h100);
    out_ready = 1'b0;
    @(posedge clk); #1;
    send_ref(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send_ref(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    drain();
    send_ref(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    drain();
    check("addr_after_3", addr, 32'h10C);
    load(32'hFFFF_FFFC);
    send_ref(7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    drain();
    @(negedge clk);
    check("addr_wrap", addr, 0);
    @(posedge clk); #1;

    // full FIFO holds the third bundle and keeps the head stable
    out_ready = 1'b0;
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0, w0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0, w1);
    fork
      send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0, wc);
      begin
        @(negedge clk);
        hold_i = instruction;
        hold_a = addr;
        check("hold_head", hold_i, 32'h002081B3);
        repeat (2) @(negedge clk);
        check("hold_in_ready", in_ready, 0);
        check("hold_instr", instruction, hold_i);
        check("hold_addr", addr, hold_a);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("held_stalled", 64'(wc >= 3), 1);
    drain();

    // rejected bundles: handshake completes, nothing pushed, sticky err
    send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h0, 1'b1, w0);
    @(negedge clk);
    check("illegal_err", err, 1);
    check("illegal_no_out", out_valid, 0);
    @(posedge clk); #1;
    load(32'h0);
    @(negedge clk);
    check("err_cleared", err, 0);
    @(posedge clk); #1;
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0, 1'b1, w0);
    @(negedge clk);
    check("jal_odd_err", err, 1);
    check("jal_odd_no_out", out_valid, 0);
    @(posedge clk); #1;
    load(32'h0);

    // error accept in the same cycle as addr_load: set wins
    in_valid = 1'b1; opcode = 7'h7F; addr_load = 1'b1; start_addr = 32'h40;
    @(negedge clk);
    @(posedge clk);
    model_err = 1'b1;
    model_addr = 32'h40;
    #1 in_valid = 1'b0; addr_load = 1'b0;
    @(negedge clk);
    check("set_beats_clear", err, 1);
    check("load_with_err_addr", addr, 32'h40);
    @(posedge clk); #1;
    load(32'h0);

    // flw f1,4(x2)
`ifdef INSTR_ENC_FP_EN
    send(7'h07, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4, 32'h00412087, 1'b0, w0);
`else
    send(7'h07, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4, 32'h0, 1'b1, w0);
`endif
    drain();
    load(32'h0);

    // reset mid-operation discards queued words
    out_ready = 1'b0;
    send_ref(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    send_ref(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
    rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    model_addr = '0;
    model_err = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_empty", out_valid, 0);
    check("midrst_instr", instruction, 0);
    @(posedge clk); #1;

    // randomized mix including occasional illegal or misaligned bundles
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h63, 7'h23, 7'h6F, 7'h07, 7'h27, 7'h7F};
    for (int i = 0; i < 60; i++) begin
      logic [6:0]  o;
      logic [31:0] im;
      o  = ops[$urandom_range(0, 11)];
      im = $urandom();
      if ((o == 7'h63 || o == 7'h6F) && $urandom_range(0, 7) != 0) im[0] = 1'b0;
      out_ready = (exp_q.size() >= DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      send_ref(o, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
               7'($urandom()), im);
      if (model_err && $urandom_range(0, 3) == 0) load(32'($urandom()) & 32'hFFFF_FFFC);
    end
    drain();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V instruction encoder. It packs decoded fields (opcode, rd, rs1, rs2, funct3, funct7, immediate) back into a 32-bit RV32I/F instruction word, which is the inverse of the instruction-decode stage. It buffers results in a small FIFO and tags each word with an auto-incrementing byte address. It sits in the program-loader/debug path that writes instruction memory, and it lets the verification environment build instruction streams from fields.

## Interface
- `DEPTH`, 2: output FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: address width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset. Synchronous and active-low.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: encoder can accept a bundle.
- `opcode` input 7: instruction bits [6:0].
- `rd`, `rs1`, `rs2` input 5 each: register indices.
- `funct3` input 3; `funct7` input 7.
- `imm` input 32: immediate, as a sign-extended value in instruction-semantic form.
- `addr_load` input 1: load the address pointer and clear the error.
- `start_addr` input ADDR_W: value loaded by `addr_load`.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer accepts the head.
- `instruction` output 32: encoded word at the FIFO head.
- `addr` output ADDR_W: byte address for the head word.
- `err` output 1: sticky error flag.

## Operation
- **Type derivation from opcode:**
  - 0110011 → R
  - 0010011 → I-ALU
  - 0000011 and 1100111 → I
  - 0110111 and 0010111 → U
  - 1100011 → B
  - 0100011 → S
  - 1101111 → J
  - 0000111 → I (FP, see Configuration)
  - 0100111 → S (FP, see Configuration)
  - anything else → illegal
- **Packing:**
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I / I-ALU: {imm[11:0], rs1, funct3, rd, opcode}.
  - I-ALU with funct3 = 001 or 101 (shifts): bits[31:25] = funct7 and bits[24:20] = imm[4:0].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Fields not used by a type are ignored. Immediate bits above the field width are ignored; no range check is performed.
- **Rejected bundles:** an illegal opcode, or B/J with imm[0] = 1, is accepted (handshake completes) but not pushed, and `err` is set. All other accepted bundles are pushed.
- **FIFO:**
  - Push on `in_valid && in_ready`.
  - Pop on `out_valid && out_ready`.
  - `in_ready` = !full. There is no bypass when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when neither full nor empty: occupancy unchanged.
  - Read and write pointers wrap modulo DEPTH.
- **Address pointer:**
  - `addr` shows the pointer value. It increments by 4 on each pop and wraps modulo 2^ADDR_W.
  - `addr_load` sets the pointer to `start_addr` and clears `err`. It takes priority over a same-cycle pop increment, but the pop itself still occurs.
  - `addr_load` does not flush the FIFO.
- **`err` priority:** an error-setting accept in the same cycle as `addr_load` leaves `err` = 1 (set wins).

## Timing
- **Reset values:** FIFO empty, `out_valid` = 0, `instruction` = 0, `addr` = 0, `err` = 0. `in_ready` = 0 while `rst_n` = 0 and 1 in the first cycle after release.
- Reset mid-operation discards all FIFO contents at the next edge.
- **Latency:** a bundle accepted at edge N appears with `out_valid` = 1 after edge N (registered; no combinational input-to-output path).
- `err` rises the cycle after the offending accept.
- **Throughput:** 1 bundle/cycle when `out_ready` is held high.
- `out_valid`, `instruction` and `addr` are stable while `out_valid && !out_ready`.

## Configuration
- `INSTR_ENC_FP_EN`: when defined, opcodes 0000111 (flw) and 0100111 (fsw) encode as I and S respectively. When undefined, both are illegal: no push, and `err` is set.

## Test plan
- add x3,x1,x2 (opcode 0110011, rd 3, rs1 1, rs2 2, funct3 0, funct7 0) → `instruction` 0x002081B3 at `addr` 0x0, one cycle after accept.
- addi x1,x0,5 → 0x00500093. sw x2,8(x1) → 0x0020A423. jal x1,8 → 0x008000EF. Send back-to-back with `out_ready` = 1 → one word per cycle, in order.
- `addr_load` with `start_addr` 0x100, then 3 pops → `addr` reads 0x100, 0x104, 0x108. A pop at 0xFFFFFFFC wraps `addr` to 0x0.
- `out_ready` = 0 with DEPTH = 2: push 2 → `in_ready` = 0, and a 3rd bundle is held. Raise `out_ready` → drain in order, then the 3rd is accepted.
- Opcode 0x7F, or jal with imm = 3 → handshake completes, no output, `err` = 1. Then `addr_load` → `err` = 0.
- flw f1,4(x2) (opcode 0000111, funct3 010) → 0x00412087 with `INSTR_ENC_FP_EN` defined; no output and `err` = 1 without it.
